smart_home_ctrl_n: RTL

SMART_HOME_CTRL_N -- requirements
Module: smart_home_ctrl_n

---
 rtl/smart_home_ctrl_n_pkg.sv | 33 +++
 rtl/smart_home_ctrl_n_if.sv | 48 ++++
 rtl/smart_home_ctrl_n_prio_enc.sv | 28 ++
 rtl/smart_home_ctrl_n.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/smart_home_ctrl_n_pkg.sv
// Shared definitions for the smart home controller.
// Holds the default parameter values, the display codes shown for each
// controller state, and the state enum itself.
// The enum values equal the display codes, so the state can be shown directly.
package smart_home_pkg;

    localparam int DEF_NUM_DOORS = 2;
    localparam int DEF_TEMP_W    = 7;
    localparam int DEF_TEMP_LOW  = 50;
    localparam int DEF_TEMP_HIGH = 85;
    localparam int DEF_HYST      = 2;
    localparam int DEF_DWELL     = 8;

    // The door index bus is always 3 bits wide, which covers up to 8 doors.
    localparam int IDX_W = 3;

    localparam logic [2:0] DISP_IDLE   = 3'b000;
    localparam logic [2:0] DISP_DOOR   = 3'b001;
    localparam logic [2:0] DISP_ALARM  = 3'b011;
    localparam logic [2:0] DISP_WINDOW = 3'b100;
    localparam logic [2:0] DISP_HEAT   = 3'b101;
    localparam logic [2:0] DISP_COOL   = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = DISP_IDLE,
        S_DOOR   = DISP_DOOR,
        S_ALARM  = DISP_ALARM,
        S_WINDOW = DISP_WINDOW,
        S_HEAT   = DISP_HEAT,
        S_COOL   = DISP_COOL
    } state_e;

endpackage

// File: rtl/smart_home_ctrl_n_if.sv
// Sensor/actuator bundle for the smart home controller.
// The modports are seen from the controller's side:
//   master - the environment: it drives the sensors and watches the actuators.
//   slave  - the controller: it reads the sensors and drives the actuators.
// Ports:
//   Clk - clock, carried along so that checkers bound to the bundle can sample it.
// Sensors:
//   door_sns - door requests
//   SW       - window sensor
//   SFA      - fire alarm sensor
//   ST       - temperature
// Actuators:
//   door_open, winbuzz, alarmbuzz, heater, cooler, display, door_idx
interface smart_home_ctrl_n_if
    import smart_home_pkg::*;
#(
    parameter int NUM_DOORS = DEF_NUM_DOORS,
    parameter int TEMP_W    = DEF_TEMP_W
) (
    input logic Clk
);

    logic [NUM_DOORS-1:0] door_sns;
    logic                 SW;
    logic                 SFA;
    logic [TEMP_W-1:0]    ST;

    logic [NUM_DOORS-1:0] door_open;
    logic                 winbuzz;
    logic                 alarmbuzz;
    logic                 heater;
    logic                 cooler;
    logic [2:0]           display;
    logic [IDX_W-1:0]     door_idx;

    modport master (
        input  Clk,
        output door_sns, SW, SFA, ST,
        input  door_open, winbuzz, alarmbuzz, heater, cooler, display, door_idx
    );

    modport slave (
        input  Clk,
        input  door_sns, SW, SFA, ST,
        output door_open, winbuzz, alarmbuzz, heater, cooler, display, door_idx
    );

endinterface

// File: rtl/smart_home_ctrl_n_prio_enc.sv
// Lowest-index priority encoder.
// Ports:
//   req   - request vector, N bits
//   idx   - index of the lowest set bit; 0 when no bit is set
//   valid - high when any bit of req is set
module prio_enc_n #(
    parameter int N     = 2,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // The scan runs from the top bit down, so the last hit it records is
    // the lowest set bit.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/smart_home_ctrl_n.sv
// Smart home controller: a Moore FSM that arbitrates between fire alarm,
// door service, window warning and heating/cooling. Arbitration order is
// ALARM > DOOR > WINDOW > HEAT > COOL > IDLE.
//
// Every output is a register loaded from the next-state decode. An input
// sampled on a clock edge therefore shows up on the outputs right after
// that same edge.
//
// display always equals the current state code. It serves as the
// state-visibility output.
//
// Ports:
//   Clk       in   clock, rising edge
//   Rst       in   asynchronous active-high reset
//   door_sns  in   door requests, bit i = door i
//   SW        in   window sensor
//   SFA       in   fire alarm sensor
//   ST        in   temperature, unsigned TEMP_W bits
//   door_open out  one-hot door actuator, active only in DOOR
//   winbuzz   out  window buzzer, active only in WINDOW
//   alarmbuzz out  alarm buzzer, active only in ALARM
//   heater    out  active only in HEAT
//   cooler    out  active only in COOL
//   display   out  state code
//   door_idx  out  index of the last door served
module smart_home_ctrl_n
    import smart_home_pkg::*;
#(
    parameter int NUM_DOORS = DEF_NUM_DOORS,
    parameter int TEMP_W    = DEF_TEMP_W,
    parameter int TEMP_LOW  = DEF_TEMP_LOW,
    parameter int TEMP_HIGH = DEF_TEMP_HIGH,
    parameter int HYST      = DEF_HYST,
    parameter int DWELL     = DEF_DWELL
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NUM_DOORS-1:0] door_sns,
    input  logic                 SW,
    input  logic                 SFA,
    input  logic [TEMP_W-1:0]    ST,
    output logic [NUM_DOORS-1:0] door_open,
    output logic                 winbuzz,
    output logic                 alarmbuzz,
    output logic                 heater,
    output logic                 cooler,
    output logic [2:0]           display,
    output logic [IDX_W-1:0]     door_idx
);

    localparam int DW_W = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL - 1);

    // Thresholds are cut to the width of the temperature bus, so every
    // comparison is unsigned at TEMP_W bits.
    localparam logic [TEMP_W-1:0] HEAT_ON  = TEMP_W'(TEMP_LOW);
    localparam logic [TEMP_W-1:0] HEAT_OFF = TEMP_W'(TEMP_LOW + HYST);
    localparam logic [TEMP_W-1:0] COOL_ON  = TEMP_W'(TEMP_HIGH);
    localparam logic [TEMP_W-1:0] COOL_OFF = TEMP_W'(TEMP_HIGH - HYST);

    state_e                 state_q;
    state_e                 state_d;
    logic [DW_W-1:0]        dwell_q;
    logic [DW_W-1:0]        dwell_d;
    logic [IDX_W-1:0]       door_idx_d;
    logic [NUM_DOORS-1:0]   door_open_d;
    logic [IDX_W-1:0]       enc_idx;
    logic                   enc_valid;
    logic                   latched_held;
    logic                   heat_hold;
    logic                   cool_hold;

    prio_enc_n #(
        .N     (NUM_DOORS),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .req   (door_sns),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // True while the door being served still requests service. This is
    // written as a compare loop so that door_idx never indexes past NUM_DOORS.
    always_comb begin
        latched_held = 1'b0;
        for (int i = 0; i < NUM_DOORS; i++) begin
            if (door_sns[i] && (door_idx == IDX_W'(i))) begin
                latched_held = 1'b1;
            end
        end
    end

    // HEAT/COOL are left only when the temperature is back past the
    // hysteresis point AND the minimum residency has run out.
    always_comb begin
        heat_hold = (state_q == S_HEAT) && !((ST >= HEAT_OFF) && (dwell_q == '0));
        cool_hold = (state_q == S_COOL) && !((ST <= COOL_OFF) && (dwell_q == '0));
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d    = S_IDLE;
        door_idx_d = door_idx;
        dwell_d    = '0;

        if (SFA) begin
            state_d = S_ALARM;
        end else if ((state_q == S_DOOR) && latched_held) begin
            // The served door keeps ownership; other doors are ignored.
            state_d = S_DOOR;
        end else if (enc_valid) begin
            state_d    = S_DOOR;
            door_idx_d = enc_idx;
        end else if (SW) begin
            state_d = S_WINDOW;
        end else if (heat_hold) begin
            state_d = S_HEAT;
        end else if (cool_hold) begin
            state_d = S_COOL;
        end else if (ST < HEAT_ON) begin
            state_d = S_HEAT;
        end else if (ST > COOL_ON) begin
            state_d = S_COOL;
        end

        // The counter reloads on every fresh entry to HEAT or COOL, which
        // includes a return after a preemption. Otherwise it runs down to zero.
        if (((state_d == S_HEAT) && (state_q != S_HEAT)) ||
            ((state_d == S_COOL) && (state_q != S_COOL))) begin
            dwell_d = DWELL_LOAD;
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - 1'b1;
        end

        door_open_d = '0;
        for (int i = 0; i < NUM_DOORS; i++) begin
            door_open_d[i] = (state_d == S_DOOR) && (door_idx_d == IDX_W'(i));
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            dwell_q   <= '0;
            door_open <= '0;
            winbuzz   <= 1'b0;
            alarmbuzz <= 1'b0;
            heater    <= 1'b0;
            cooler    <= 1'b0;
            display   <= DISP_IDLE;
            door_idx  <= '0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            door_open <= door_open_d;
            winbuzz   <= (state_d == S_WINDOW);
            alarmbuzz <= (state_d == S_ALARM);
            heater    <= (state_d == S_HEAT);
            cooler    <= (state_d == S_COOL);
            display   <= state_d;
            door_idx  <= door_idx_d;
        end
    end

endmodule
